// File: rtl/psg_write_controller_if.sv
// ----------------------------------------------------------------------------
// psg_write_controller_if
// Host-side write bus of the PSG control-register file.
//   data  : command byte, held stable by the host from we_n fall until ready rises
//   we_n  : asynchronous active-low write strobe
//   ready : high when the controller is idle and can accept a write
// Modports:
//   master : host side (drives data/we_n, observes ready)
//   slave  : controller side (observes data/we_n, drives ready)
// ----------------------------------------------------------------------------
interface psg_write_controller_if;
    logic [7:0] data;
    logic       we_n;
    logic       ready;

    modport master (output data, output we_n, input ready);
    modport slave  (input data, input we_n, output ready);
endinterface

// File: rtl/psg_write_controller.sv
// ----------------------------------------------------------------------------
// psg_write_controller
// Host write interface and control-register file for an SN76489-compatible
// PSG. Decodes latch/data command bytes from an asynchronous write strobe and
// holds the attenuation, tone-period and noise-control registers.
//
// Parameters:
//   BUSY_CYCLES   : cycles ready stays low after a write is committed (>=1)
// Ports:
//   i_clk         : system clock
//   i_rst_n       : asynchronous active-low reset
//   host          : host write bus (data, we_n, ready), slave side
//   o_attn        : attenuation {ch3,ch2,ch1,ch0}, 4 bits each (ch3 = noise)
//   o_tone_freq   : tone periods {t2,t1,t0}, 10 bits each
//   o_noise_ctrl  : bit2 = white/periodic, bits1:0 = rate
//   o_noise_reset : one-cycle pulse on every noise-control write
// ----------------------------------------------------------------------------
module psg_write_controller #(
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    psg_write_controller_if.slave   host,
    output logic [15:0]             o_attn,
    output logic [29:0]             o_tone_freq,
    output logic [2:0]              o_noise_ctrl,
    output logic                    o_noise_reset
);

    localparam int unsigned    CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_BUSY,
        S_WAIT_RELEASE
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s2_d;
    logic [7:0]       r_byte;
    logic [1:0]       r_ch;
    logic             r_vol;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic [15:0]      r_attn;
    logic [29:0]      r_tone;
    logic [2:0]       r_noise_ctrl;
    logic             r_noise_reset;

    logic             w_write_edge;
    logic             w_is_latch;
    logic [1:0]       w_ch;
    logic             w_vol;
    logic [4:0]       w_tone_lo;

    // Synchronizer resets to 1 so a strobe held low across reset release
    // still produces exactly one falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_s2_d <= 1'b1;
        end else begin
            r_s1   <= host.we_n;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign w_write_edge = ~r_s2 & r_s2_d;

    // A latch byte carries its own channel/type; a data byte reuses the
    // previously latched ones.
    assign w_is_latch = r_byte[7];
    assign w_ch       = w_is_latch ? r_byte[6:5] : r_ch;
    assign w_vol      = w_is_latch ? r_byte[4]   : r_vol;

    always_comb begin
        w_tone_lo = 5'd0;
        case (w_ch)
            2'd1:    w_tone_lo = 5'd10;
            2'd2:    w_tone_lo = 5'd20;
            default: w_tone_lo = 5'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_byte        <= '0;
            r_ch          <= '0;
            r_vol         <= 1'b0;
            r_cnt         <= '0;
            r_ready       <= 1'b1;
            r_attn        <= '1;
            r_tone        <= '0;
            r_noise_ctrl  <= '0;
            r_noise_reset <= 1'b0;
        end else begin
            r_noise_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_write_edge) begin
                        r_byte  <= host.data;
                        r_ready <= 1'b0;
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (w_is_latch) begin
                        r_ch  <= r_byte[6:5];
                        r_vol <= r_byte[4];
                    end
                    if (w_vol) begin
                        r_attn[{w_ch, 2'b00} +: 4] <= r_byte[3:0];
                    end else if (w_ch == 2'd3) begin
                        r_noise_ctrl  <= r_byte[2:0];
                        r_noise_reset <= 1'b1;
                    end else if (w_is_latch) begin
                        r_tone[w_tone_lo +: 4] <= r_byte[3:0];
                    end else begin
                        r_tone[(w_tone_lo + 5'd4) +: 6] <= r_byte[5:0];
                    end
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (r_s2) begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_RELEASE: begin
                    if (r_s2) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign host.ready    = r_ready;
    assign o_attn        = r_attn;
    assign o_tone_freq   = r_tone;
    assign o_noise_ctrl  = r_noise_ctrl;
    assign o_noise_reset = r_noise_reset;

endmodule

// File: tb/tb_psg_write_controller.sv
// ----------------------------------------------------------------------------
// tb_psg_write_controller
// Directed and randomized write sequences against a register-level model of
// the PSG command decode; checks register contents, ready timing and
// noise_reset pulses.
// ----------------------------------------------------------------------------
module tb_psg_write_controller;

    localparam int unsigned N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] attn;
    logic [29:0] tone;
    logic [2:0]  noise;
    logic        nrst;

    psg_write_controller_if host ();

    psg_write_controller #(.BUSY_CYCLES(N)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .host          (host),
        .o_attn        (attn),
        .o_tone_freq   (tone),
        .o_noise_ctrl  (noise),
        .o_noise_reset (nrst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    // Each one-cycle noise_reset pulse is seen at exactly one falling edge.
    always @(negedge clk) if (nrst === 1'b1) npulse++;

    // ---------------- reference model ----------------
    logic [3:0] m_att [4];
    logic [9:0] m_tone [3];
    logic [2:0] m_noise;
    int         m_ch;
    bit         m_vol;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_att[i] = 4'hF;
        for (int i = 0; i < 3; i++) m_tone[i] = 10'h000;
        m_noise = 3'b000;
        m_ch    = 0;
        m_vol   = 1'b0;
    endfunction

    // Returns 1 when the byte writes the noise register.
    function automatic bit m_apply(input logic [7:0] b);
        if (b[7]) begin
            m_ch  = int'(b[6:5]);
            m_vol = b[4];
        end
        if (m_vol) begin
            m_att[m_ch] = b[3:0];
            return 1'b0;
        end else if (m_ch == 3) begin
            m_noise = b[2:0];
            return 1'b1;
        end else if (b[7]) begin
            m_tone[m_ch] = (m_tone[m_ch] & 10'h3F0) | {6'd0, b[3:0]};
        end else begin
            m_tone[m_ch] = {b[5:0], m_tone[m_ch][3:0]};
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] e_attn();
        return {m_att[3], m_att[2], m_att[1], m_att[0]};
    endfunction

    function automatic logic [29:0] e_tone();
        return {m_tone[2], m_tone[1], m_tone[0]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_attn"},  32'(attn),  32'(e_attn()));
        chk({tag, "_tone"},  32'(tone),  32'(e_tone()));
        chk({tag, "_noise"}, 32'(noise), 32'(m_noise));
    endtask

    // One host write: we_n low across `lowcyc` edges (1..3), optional extra
    // strobe while busy that must be ignored.
    task automatic do_write(input logic [7:0] b, input int lowcyc, input bit glitch);
        int   cnt;
        int   p0;
        bit   expp;
        logic [7:0] gb;
        chk("ready_idle", 32'(host.ready), 32'd1);
        @(posedge clk); #2;
        host.data = b;
        host.we_n = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            if (e == 1) chk("ready_e1", 32'(host.ready), 32'd1);
            if (e == 2) begin
                chk("ready_fall", 32'(host.ready), 32'd0);
                chk_regs("pre_commit");
            end
            if (e + 1 == lowcyc) begin #1; host.we_n = 1'b1; end
        end
        p0   = npulse;
        expp = m_apply(b);
        @(posedge clk); #1;
        chk_regs("commit");
        chk("nrst_commit", 32'(nrst), 32'(expp));
        gb  = {4'h9, ~m_att[0]};
        cnt = 0;
        while (host.ready !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (glitch && cnt == 5) begin host.data = gb; host.we_n = 1'b0; end
            if (glitch && cnt == 9) begin host.we_n = 1'b1; host.data = b; end
        end
        chk("busy_len", 32'(cnt), 32'(N));
        chk("noise_pulses", 32'(npulse - p0), 32'(expp));
        chk_regs("after");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        int         p0;

        host.we_n = 1'b1;
        host.data = 8'h00;
        m_reset();

        repeat (3) @(posedge clk); #1;
        chk_regs("rst");
        chk("rst_ready", 32'(host.ready), 32'd1);
        chk("rst_nrst", 32'(nrst), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk_regs("idle");
            chk("idle_ready", 32'(host.ready), 32'd1);
        end

        do_write(8'h8E, 2, 1'b0);
        do_write(8'h0F, 1, 1'b0);
        chk("tone0_0FE", 32'(tone[9:0]), 32'h0FE);
        do_write(8'hD5, 1, 1'b0);
        do_write(8'h03, 3, 1'b0);
        do_write(8'hE6, 2, 1'b0);
        chk("noise_110", 32'(noise), 32'd6);
        do_write(8'h01, 1, 1'b0);
        chk("noise_001", 32'(noise), 32'd1);

        // we_n held low for 200 cycles: exactly one write.
        p0 = npulse;
        @(posedge clk); #2;
        host.data = 8'h9A;
        host.we_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("hold_ready_fall", 32'(host.ready), 32'd0);
        void'(m_apply(8'h9A));
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 10) host.data = 8'h55;
        end
        chk("hold_ready_low", 32'(host.ready), 32'd0);
        chk("hold_attn0", 32'(attn[3:0]), 32'hA);
        chk_regs("hold");
        #1 host.we_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_s1", 32'(host.ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_s2", 32'(host.ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_ready", 32'(host.ready), 32'd1);
        chk("hold_pulses", 32'(npulse - p0), 32'd0);
        chk_regs("post_hold");

        // Extra strobe while busy is ignored.
        do_write(8'hC7, 1, 1'b1);
        repeat (6) @(posedge clk); #1;
        chk_regs("post_glitch");

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            rb = 8'($urandom);
            do_write(rb, int'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0));
        end

        // Reset during BUSY.
        @(posedge clk); #2;
        host.data = 8'hBF;
        host.we_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 host.we_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("pre_rst_busy", 32'(host.ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        chk_regs("rst_busy");
        chk("rst_busy_ready", 32'(host.ready), 32'd1);
        chk("rst_busy_nrst", 32'(nrst), 32'd0);
        #2 rst_n = 1'b1;
        repeat (50) @(posedge clk); #1;
        chk_regs("post_rst_busy");
        chk("post_rst_ready", 32'(host.ready), 32'd1);

        // Reset while in COMMIT discards the captured byte.
        @(posedge clk); #2;
        host.data = 8'h9C;
        host.we_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 host.we_n = 1'b1;
        @(posedge clk); #1;
        chk("commit_ready", 32'(host.ready), 32'd0);
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        repeat (40) @(posedge clk); #1;
        chk_regs("discard");
        chk("discard_ready", 32'(host.ready), 32'd1);

        // Data byte with no latch since reset targets tone 0.
        do_write(8'h15, 1, 1'b0);
        chk("reset_latch_tone0", 32'(tone[9:0]), 32'h150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
